// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS data-memory store path.
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_RESP
  } state_t;

  // True when the request cannot be performed: illegal size or address
  // not aligned to the access width.
  function automatic logic store_bad(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lane[0];
      SZ_WORD: bad = (lane != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane merge: drops the narrowed store data into the addressed
// little-endian lanes of the old memory word and flags lossy truncation.
module store_lane_merge
  import mips_mem_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  input  logic [1:0]  size,
  input  logic [1:0]  addr,
  output logic [31:0] merged_word,
  output logic        lossy
);

  logic [WORD_BYTES-1:0] lane_en;
  logic [31:0]           lane_data;

  // Pick the written lanes and the replicated store data, then mux per lane.
  always_comb begin
    lane_en   = '0;
    lane_data = new_data;
    lossy     = 1'b0;
    case (size)
      SZ_BYTE: begin
        lane_en   = 4'b0001 << addr;
        lane_data = {4{new_data[7:0]}};
        lossy     = (new_data[31:8] != {24{new_data[7]}});
      end
      SZ_HALF: begin
        lane_en   = addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{new_data[15:0]}};
        lossy     = (new_data[31:16] != {16{new_data[15]}});
      end
      SZ_WORD: begin
        lane_en   = '1;
        lane_data = new_data;
      end
      default: begin
        lane_en   = '0;
      end
    endcase
    merged_word = old_word;
    for (int unsigned k = 0; k < WORD_BYTES; k++) begin
      if (lane_en[k]) begin
        merged_word[8*k +: 8] = lane_data[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/store_narrow_unit.sv
// Store-path narrowing unit: truncates a register value to byte/half/word and
// writes it to word-wide memory, using read-modify-write for sub-word stores.
module store_narrow_unit
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        req_size,
  output logic              done,
  output logic              err,
  output logic              lossy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_wack
);

  state_t              state_q, state_d;
  logic [1:0]          lane_q, lane_d;
  logic [31:0]         data_q, data_d;
  logic [1:0]          size_q, size_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic                mem_rd_d, mem_wr_d;
  logic [31:0]         mem_wdata_d;
  logic                done_d, err_d, lossy_d;

  logic [31:0]         merged_word;
  logic                merge_lossy;

  store_lane_merge u_merge (
    .old_word    (mem_rdata),
    .new_data    (data_q),
    .size        (size_q),
    .addr        (lane_q),
    .merged_word (merged_word),
    .lossy       (merge_lossy)
  );

  assign req_ready = (state_q == ST_IDLE);

  // Next-state and next-output decode; all outputs are registered, so each
  // transition computes the values that appear in the following state.
  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    data_d      = data_q;
    size_d      = size_q;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    lossy_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          lane_d = req_addr[1:0];
          data_d = req_data;
          size_d = req_size;
          if (store_bad(req_size, req_addr[1:0])) begin
            state_d = ST_RESP;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else if (req_size == SZ_WORD) begin
            state_d     = ST_WR;
            mem_wr_d    = 1'b1;
            mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
            mem_wdata_d = req_data;
          end else begin
            state_d    = ST_RD;
            mem_rd_d   = 1'b1;
            mem_addr_d = {req_addr[ADDR_W-1:2], 2'b00};
          end
        end
      end
      ST_RD: begin
        if (mem_rvalid) begin
          state_d     = ST_WR;
          mem_wr_d    = 1'b1;
          mem_wdata_d = merged_word;
        end else begin
          mem_rd_d = 1'b1;
        end
      end
      ST_WR: begin
        if (mem_wack) begin
          state_d = ST_RESP;
          done_d  = 1'b1;
          lossy_d = merge_lossy;
        end else begin
          mem_wr_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      lane_q    <= '0;
      data_q    <= '0;
      size_q    <= '0;
      mem_addr  <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_wdata <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      lossy     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      data_q    <= data_d;
      size_q    <= size_d;
      mem_addr  <= mem_addr_d;
      mem_rd    <= mem_rd_d;
      mem_wr    <= mem_wr_d;
      mem_wdata <= mem_wdata_d;
      done      <= done_d;
      err       <= err_d;
      lossy     <= lossy_d;
    end
  end

endmodule

// File: tb/tb_store_narrow_unit.sv
// Bench for store_narrow_unit: directed scenarios plus random stores checked
// against a byte-level memory model with configurable memory latencies.
module tb_store_narrow_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic [1:0]  req_size = '0;
  logic        done, err, lossy;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [31:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic        mem_wack = 1'b0;

  int unsigned passed = 0;
  int unsigned total  = 0;

  int unsigned rd_lat = 0, wr_lat = 0;
  int unsigned rd_cnt = 0, wr_cnt = 0;

  logic [31:0] mem_arr [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  store_narrow_unit #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_size   (req_size),
    .done       (done),
    .err        (err),
    .lossy      (lossy),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .mem_wr     (mem_wr),
    .mem_wdata  (mem_wdata),
    .mem_wack   (mem_wack)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
  endfunction

  function logic [31:0] mem_word(input logic [31:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return init_word(a);
  endfunction

  function logic [31:0] ref_word(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_word(a);
  endfunction

  // Memory responder: answers after rd_lat/wr_lat extra cycles of request.
  always @(negedge clk) begin
    if (mem_rd) begin
      mem_rvalid = (rd_cnt >= rd_lat);
      rd_cnt++;
    end else begin
      mem_rvalid = 1'b0;
      rd_cnt = 0;
    end
    if (mem_wr) begin
      mem_wack = (wr_cnt >= wr_lat);
      wr_cnt++;
    end else begin
      mem_wack = 1'b0;
      wr_cnt = 0;
    end
    mem_rdata = mem_word(mem_addr);
  end

  // Memory array commit on an accepted write.
  always @(posedge clk) begin
    if (mem_wr && mem_wack) mem_arr[mem_addr] = mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Issue one store starting at a negedge with the unit idle; returns at the
  // negedge after the done pulse, with the unit idle again.
  task automatic do_store(input string name, input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] sz, input int unsigned rl, input int unsigned wl);
    logic [31:0] wa, exp_word;
    int unsigned nbytes, lane, exp_lat, exp_rd, exp_wr, cyc, lat, rd_cyc, wr_cyc;
    logic exp_err, exp_lossy, got_done, got_err, got_lossy, ready_ok, wr_ok, rd_ok;
    longint sv, lim;

    wa      = {a[31:2], 2'b00};
    lane    = a % 4;
    nbytes  = (sz == 2'd3) ? 0 : (1 << sz);
    exp_err = (sz == 2'd3) || ((a % nbytes) != 0);
    exp_word = ref_word(wa);
    exp_lossy = 1'b0;
    if (!exp_err) begin
      for (int unsigned i = 0; i < nbytes; i++) exp_word[8*(lane+i) +: 8] = d[8*i +: 8];
      if (nbytes < 4) begin
        sv  = longint'($signed(d));
        lim = longint'(1) << (8*nbytes - 1);
        exp_lossy = (sv < -lim) || (sv > lim - 1);
      end
    end
    exp_lat = exp_err ? 1 : (nbytes == 4 ? 2 + wl : 3 + rl + wl);
    exp_rd  = (exp_err || nbytes == 4) ? 0 : rl + 1;
    exp_wr  = exp_err ? 0 : wl + 1;

    rd_lat = rl;
    wr_lat = wl;
    check({name, " ready_before"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    req_size  = sz;

    cyc = 0; lat = 0; rd_cyc = 0; wr_cyc = 0;
    got_done = 1'b0; got_err = 1'b0; got_lossy = 1'b0;
    ready_ok = 1'b1; wr_ok = 1'b1; rd_ok = 1'b1;
    while (!got_done && cyc < 64) begin
      @(negedge clk);
      cyc++;
      req_valid = 1'b0;
      req_addr  = $urandom;
      req_data  = $urandom;
      req_size  = 2'($urandom_range(0, 3));
      if (req_ready) ready_ok = 1'b0;
      if (mem_rd) begin
        rd_cyc++;
        if (mem_addr !== wa) rd_ok = 1'b0;
      end
      if (mem_wr) begin
        wr_cyc++;
        if (mem_addr !== wa || mem_wdata !== exp_word) wr_ok = 1'b0;
      end
      if (mem_rd && mem_wr) rd_ok = 1'b0;
      if (done) begin
        got_done  = 1'b1;
        lat       = cyc;
        got_err   = err;
        got_lossy = lossy;
      end
    end
    req_valid = 1'b0;

    check({name, " done_seen"}, 32'(got_done), 32'd1);
    check({name, " latency"}, lat, exp_lat);
    check({name, " err"}, 32'(got_err), 32'(exp_err));
    check({name, " lossy"}, 32'(got_lossy), 32'(exp_lossy));
    check({name, " rd_cycles"}, rd_cyc, exp_rd);
    check({name, " wr_cycles"}, wr_cyc, exp_wr);
    check({name, " busy_not_ready"}, 32'(ready_ok), 32'd1);
    check({name, " rd_addr_stable"}, 32'(rd_ok), 32'd1);
    check({name, " wr_word_stable"}, 32'(wr_ok), 32'd1);

    if (!exp_err) ref_mem[wa] = exp_word;
    @(negedge clk);
    check({name, " done_pulse"}, 32'(done), 32'd0);
    check({name, " ready_after"}, 32'(req_ready), 32'd1);
    check({name, " mem_content"}, mem_word(wa), ref_word(wa));
  endtask

  initial begin
    int unsigned n;
    logic [31:0] ra, rd;
    logic [1:0]  rs;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst req_ready", 32'(req_ready), 32'd1);
    check("rst done", 32'(done), 32'd0);
    check("rst err", 32'(err), 32'd0);
    check("rst lossy", 32'(lossy), 32'd0);
    check("rst mem_rd", 32'(mem_rd), 32'd0);
    check("rst mem_wr", 32'(mem_wr), 32'd0);
    check("rst mem_addr", mem_addr, 32'd0);
    check("rst mem_wdata", mem_wdata, 32'd0);

    // Directed scenarios
    do_store("word", 32'h100, 32'hDEADBEEF, 2'b10, 0, 0);
    do_store("setup200", 32'h200, 32'h11223344, 2'b10, 0, 0);
    do_store("byte", 32'h203, 32'h000000AB, 2'b00, 0, 0);
    check("byte merged", mem_word(32'h200), 32'hAB223344);
    do_store("setup300a", 32'h300, 32'hFFFFFFFF, 2'b10, 0, 0);
    do_store("half_lossy", 32'h302, 32'h00018000, 2'b01, 0, 0);
    check("half merged", mem_word(32'h300), 32'h8000FFFF);
    do_store("setup300b", 32'h300, 32'hFFFFFFFF, 2'b10, 0, 0);
    do_store("half_clean", 32'h302, 32'hFFFF8000, 2'b01, 0, 0);
    do_store("mis_half", 32'h401, 32'h12345678, 2'b01, 0, 0);
    do_store("bad_size", 32'h400, 32'h12345678, 2'b11, 0, 0);
    do_store("mis_word", 32'h402, 32'h12345678, 2'b10, 0, 0);
    do_store("backpressure", 32'h601, 32'hFFFFFF80, 2'b00, 3, 2);
    do_store("b2b_1", 32'h700, 32'h01020304, 2'b10, 0, 0);
    do_store("b2b_2", 32'h704, 32'h05060708, 2'b10, 0, 0);

    // Reset while the write is pending: write must be abandoned
    rd_lat = 0;
    wr_lat = 6;
    req_valid = 1'b1;
    req_addr  = 32'h500;
    req_data  = 32'h00000077;
    req_size  = 2'b00;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!mem_wr && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("rstwr reached_wr", 32'(mem_wr), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rstwr mem_wr", 32'(mem_wr), 32'd0);
    check("rstwr mem_rd", 32'(mem_rd), 32'd0);
    check("rstwr done", 32'(done), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rstwr ready", 32'(req_ready), 32'd1);
    check("rstwr no_done", 32'(done), 32'd0);
    check("rstwr mem_untouched", mem_word(32'h500), ref_word(32'h500));
    do_store("after_rst", 32'h501, 32'hFFFFFF99, 2'b00, 1, 0);

    // Random stores
    for (int i = 0; i < 40; i++) begin
      ra = 32'h1000 + (32'($urandom_range(0, 15)) << 2) + 32'($urandom_range(0, 3));
      rs = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0: rd = $urandom;
        1: begin rd = $urandom; rd = {{24{rd[7]}}, rd[7:0]}; end
        default: begin rd = $urandom; rd = {{16{rd[15]}}, rd[15:0]}; end
      endcase
      do_store($sformatf("rand%0d", i), ra, rd, rs,
               $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/store_narrow_unit.md
# store_narrow_unit

Store-path narrowing unit for the 32-bit MIPS datapath, the inverse of the load-side sign extension. Takes a 32-bit register value plus a store size (byte/half/word), truncates it to the stored width, and writes it into word-wide data memory. Data memory has no byte enables, so sub-word stores run as a read-modify-write sequence. It sits between the EX/MEM stage and the data memory port, and stalls the pipeline through `req_ready` until the store is finished.

## Interface
- `ADDR_W`, 32, byte-address width.
- `clk  in  1  system clock; all state changes on the rising edge`
- `rst  in  1  reset, synchronous, active-high`
- `req_valid  in  1  store request present`
- `req_ready  out  1  unit idle, can accept a request`
- `req_addr  in  ADDR_W  byte address`
- `req_data  in  32  register value to store`
- `req_size  in  2  00 byte, 01 half, 10 word, 11 illegal`
- `done  out  1  one-cycle completion pulse`
- `err  out  1  valid with `done`: misaligned or illegal size, no memory access made`
- `lossy  out  1  valid with `done`: discarded upper bits are not a sign extension of the stored part`
- `mem_addr  out  ADDR_W  word address, bits [1:0] always 0`
- `mem_rd  out  1  read request, held until `mem_rvalid``
- `mem_rdata  in  32  read data, sampled when `mem_rvalid``
- `mem_rvalid  in  1  read data valid`
- `mem_wr  out  1  write request, held until `mem_wack``
- `mem_wdata  out  32  merged write word`
- `mem_wack  in  1  write accepted`

## Operation
- A request is accepted when `req_valid && req_ready`. At acceptance, `req_addr`, `req_data` and `req_size` are latched.
- `req_ready` is 1 only in the IDLE state.
- FSM states are IDLE, RD, WR and RESP.
- From IDLE on acceptance:
  - Illegal size, half with `addr[0]=1`, or word with `addr[1:0]!=0`: go to RESP with `err=1`. No memory access is made.
  - Word store: go to WR with `mem_wdata=req_data`.
  - Byte or half store: go to RD.
- RD: hold `mem_rd=1` with `mem_addr={addr[ADDR_W-1:2],2'b00}`. On `mem_rvalid`, latch the merged word and go to WR.
- WR: hold `mem_wr=1` with the same `mem_addr`. On `mem_wack`, go to RESP.
- RESP: pulse `done` for one cycle, with `err` and `lossy` valid, then return to IDLE.
- Byte merge uses little-endian lanes. With lane `k=addr[1:0]`, bits `[8k+7:8k]` are replaced by `req_data[7:0]`; all other bits keep `mem_rdata`.
- Half merge uses `h=addr[1]`. Bits `[16h+15:16h]` are replaced by `req_data[15:0]`.
- `lossy` rules:
  - Byte store: `lossy = !(req_data[31:8]` all equal to `req_data[7])`.
  - Half store: same test on bits `[31:16]` against `req_data[15]`.
  - Word store: `lossy=0`.
  - Errored request: `lossy=0`.
- `mem_rvalid` is ignored outside RD, and `mem_wack` is ignored outside WR.
- `req_*` inputs are ignored while not in IDLE.

## Timing
- Reset values: state IDLE, so `req_ready=1` from the first cycle after reset. `done=0`, `err=0`, `lossy=0`, `mem_rd=0`, `mem_wr=0`, `mem_addr=0`, `mem_wdata=0`.
- All `mem_*`, `done`, `err` and `lossy` outputs are registered. `req_ready` is decoded from state.
- Latency, with acceptance at cycle T and memory responding in the same cycle a request is first asserted:
  - Word store: `mem_wr` at T+1, `done` at T+2.
  - Sub-word store: `mem_rd` at T+1, `mem_wr` at T+2, `done` at T+3.
  - Error: `done`/`err` at T+1.
- Every extra wait cycle on `mem_rvalid` or `mem_wack` adds one cycle to the latency.
- Back-to-back: a new request can be accepted in the cycle after RESP, so the peak rate is one word store per 3 cycles.
- Reset mid-operation: on the edge where `rst=1`, `mem_rd`/`mem_wr` drop and state returns to IDLE. No `done` is produced. A write already acknowledged stays committed.
- `mem_rvalid` arriving in the same cycle that `mem_rd` is first raised is legal and is accepted.

## Structure
- Shared package `mips_mem_pkg` holds:
  - Size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`.
  - The state enum.
  - The constant `WORD_BYTES=4`.
- Sub-module `store_lane_merge` is purely combinational. Inputs: `old_word`, `new_data`, `size`, `addr[1:0]`. Outputs: `merged_word` and `lossy`. It is instantiated once.

## Test plan
- Word store: addr `0x100`, data `0xDEADBEEF`, `wack` immediate. Require `mem_wr` at T+1 with `mem_wdata=0xDEADBEEF`, no `mem_rd`, and `done` at T+2 with `err=0`, `lossy=0`.
- Byte store: addr `0x203`, data `0x000000AB`, `rdata=0x11223344`. Require `mem_addr=0x200` and `mem_wdata=0xAB223344`, with `done` at T+3.
- Half store: addr `0x302`, data `0x00018000`, `rdata=0xFFFFFFFF`. Require `mem_wdata=0x8000FFFF` and `lossy=1`. Repeat with data `0xFFFF8000`: require `lossy=0`.
- Misaligned half (addr `0x401`) and size `11`: require `done`/`err` at T+1 with no `mem_rd`/`mem_wr` ever asserted.
- Backpressure: hold `mem_rvalid` low for 3 cycles, then `mem_wack` low for 2 cycles. Require `mem_rd`/`mem_wr` stable through the waits, `req_ready=0` throughout, and `done` at T+8.
- Assert `rst` during WR. Require `mem_wr=0` at the next edge, no `done`, `req_ready=1` after reset, and correct handling of a following request.
